batch_fifo: RTL and testbench

Multi-lane in-order FIFO that accepts up to LANES entries per cycle from a producer presenting a continuous-prefix valid mask. It delivers up to LANES entries per cycle to a consumer as a continuous-prefix valid mask. Where count-one logic turns a prefix mask into a count, this block does the reverse on its output side: an occupancy count becomes a prefix valid mask. It sits between superscalar pipeline stages (e.g. fetch→decode, decode→rename) as the batch buffer.

---
 rtl/batch_fifo_pkg.sv | 25 ++
 rtl/batch_fifo_count_to_mask.sv | 15 +
 rtl/batch_fifo.sv | 106 ++++++++++
 tb/tb_batch_fifo.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/batch_fifo_pkg.sv
// Shared types and helpers for batch_fifo: lane-count/pointer types and leading-ones run length.
// Types are sized for the default configuration; the top derives its widths from its own parameters.
package batch_fifo_pkg;
    localparam int BF_LANES = 4;
    localparam int BF_DEPTH = 16;
    localparam int LANE_MAX = 16;

    typedef logic [$clog2(BF_LANES):0] lane_cnt_t;
    typedef logic [$clog2(BF_DEPTH):0] ptr_t;

    // Length of the unbroken run of ones starting at bit 0, looking at the low n bits only.
    function automatic int lead_ones(input logic [LANE_MAX-1:0] v, input int n);
        int   r;
        logic run;
        r   = 0;
        run = 1'b1;
        for (int i = 0; i < LANE_MAX; i++) begin
            if (i < n) begin
                if (run && v[i]) r = r + 1;
                else             run = 1'b0;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/batch_fifo_count_to_mask.sv
// Turns a lane count into a prefix mask: lane i is set when i < count. Purely combinational.
module count_to_mask #(
    parameter int LANES = 4,
    parameter int CW    = $clog2(LANES) + 1
) (
    input  logic [CW-1:0]    i_cnt,
    output logic [LANES-1:0] o_mask
);
    always_comb begin
        o_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            o_mask[i] = (i < int'(i_cnt));
        end
    end
endmodule

// File: rtl/batch_fifo.sv
// Multi-lane in-order FIFO: up to LANES pushes and pops per cycle, 1-cycle push-to-pop, no bypass.
// Optional input-protocol checker enabled by defining BATCH_FIFO_CHECK_EN.
module batch_fifo
    import batch_fifo_pkg::*;
#(
    parameter int LANES      = BF_LANES,
    parameter int DEPTH      = BF_DEPTH,
    parameter int DATA_WIDTH = 32,
    localparam int CW = $clog2(LANES) + 1,
    localparam int PW = $clog2(DEPTH) + 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_flush,
    input  logic [LANES-1:0]                 i_push_valid,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] i_push_data,
    output logic [CW-1:0]                    o_push_ready_cnt,
    output logic [CW-1:0]                    o_push_accept_cnt,
    output logic [LANES-1:0]                 o_pop_valid,
    output logic [LANES-1:0][DATA_WIDTH-1:0] o_pop_data,
    input  logic [CW-1:0]                    i_pop_cnt,
    output logic [PW-1:0]                    o_count,
    output logic                             o_full,
    output logic                             o_empty
);
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [PW-1:0]    w_count;
    logic [PW-1:0]    w_free;
    logic [CW-1:0]    w_ready;
    logic [CW-1:0]    w_avail;
    logic [CW-1:0]    w_run;
    logic [CW-1:0]    w_accept;
    logic [CW-1:0]    w_eff_pop;
    logic [LANES-1:0] w_wr_mask;
    logic [AW-1:0]    w_wr_idx [LANES];
    logic [AW-1:0]    w_rd_idx [LANES];

    // Everything the consumer/producer sees as status comes from the pointers only.
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_free   = PW'(DEPTH) - w_count;
    assign w_ready  = (w_free  >= PW'(LANES)) ? CW'(LANES) : CW'(w_free);
    assign w_avail  = (w_count >= PW'(LANES)) ? CW'(LANES) : CW'(w_count);
    assign w_run    = CW'(lead_ones(LANE_MAX'(i_push_valid), LANES));
    assign w_accept = i_flush ? '0 : ((w_run < w_ready) ? w_run : w_ready);
    assign w_eff_pop = (i_pop_cnt < w_avail) ? i_pop_cnt : w_avail;

    assign o_push_ready_cnt  = w_ready;
    assign o_push_accept_cnt = w_accept;
    assign o_count           = w_count;
    assign o_full            = (w_count == PW'(DEPTH));
    assign o_empty           = (w_count == '0);

    count_to_mask #(.LANES(LANES), .CW(CW)) u_pop_mask (
        .i_cnt  (w_avail),
        .o_mask (o_pop_valid)
    );

    count_to_mask #(.LANES(LANES), .CW(CW)) u_wr_mask (
        .i_cnt  (w_accept),
        .o_mask (w_wr_mask)
    );

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_wr_idx[i]   = r_wr_ptr[AW-1:0] + AW'(i);
            w_rd_idx[i]   = r_rd_ptr[AW-1:0] + AW'(i);
            o_pop_data[i] = r_mem[w_rd_idx[i]];
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_wr_mask[i]) r_mem[w_wr_idx[i]] <= i_push_data[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_accept);
            r_rd_ptr <= r_rd_ptr + PW'(w_eff_pop);
        end
    end

`ifdef BATCH_FIFO_CHECK_EN
    always @(posedge i_clk) begin
        if (i_rst_n) begin
            assert ($countones(i_push_valid) == int'(w_run))
                else $error("batch_fifo: push_valid %b is not a prefix mask", i_push_valid);
            assert (i_pop_cnt <= w_avail)
                else $error("batch_fifo: pop_cnt %0d exceeds available %0d", i_pop_cnt, w_avail);
        end
    end
`else
    // Clamping above keeps the datapath safe without the checker.
`endif
endmodule

// File: tb/tb_batch_fifo.sv
module tb_batch_fifo;
    localparam int LANES = 4;
    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int CW    = $clog2(LANES) + 1;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic                        clk;
    logic                        rst_n;
    logic                        flush;
    logic [LANES-1:0]            push_valid;
    logic [LANES-1:0][DW-1:0]    push_data;
    logic [CW-1:0]               push_ready_cnt;
    logic [CW-1:0]               push_accept_cnt;
    logic [LANES-1:0]            pop_valid;
    logic [LANES-1:0][DW-1:0]    pop_data;
    logic [CW-1:0]               pop_cnt;
    logic [PW-1:0]               count;
    logic                        full;
    logic                        empty;

    int checks   = 0;
    int failures = 0;

    batch_fifo #(.LANES(LANES), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_flush           (flush),
        .i_push_valid      (push_valid),
        .i_push_data       (push_data),
        .o_push_ready_cnt  (push_ready_cnt),
        .o_push_accept_cnt (push_accept_cnt),
        .o_pop_valid       (pop_valid),
        .o_pop_data        (pop_data),
        .i_pop_cnt         (pop_cnt),
        .o_count           (count),
        .o_full            (full),
        .o_empty           (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic [LANES-1:0] v, input logic [DW-1:0] base);
        push_valid = v;
        for (int l = 0; l < LANES; l++) push_data[l] = base + DW'(l);
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        push_valid = '0;
        push_data  = '0;
        pop_cnt    = '0;

        // 1. reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_pop_valid", 64'(pop_valid), 64'h0);
        check("rst_ready", 64'(push_ready_cnt), 64'd4);

        // 2. prefix push of A,B,C
        push_valid = 4'b0111;
        push_data[0] = 32'hA; push_data[1] = 32'hB; push_data[2] = 32'hC; push_data[3] = 32'hD;
        #1;
        check("p2_accept", 64'(push_accept_cnt), 64'd3);
        check("p2_no_bypass", 64'(pop_valid), 64'h0);
        tick();
        push_valid = '0;
        #1;
        check("p2_count", 64'(count), 64'd3);
        check("p2_pop_valid", 64'(pop_valid), 64'b0111);
        check("p2_lane0", 64'(pop_data[0]), 64'hA);
        check("p2_lane1", 64'(pop_data[1]), 64'hB);
        check("p2_lane2", 64'(pop_data[2]), 64'hC);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("clr_count", 64'(count), 64'd0);

        // 3. non-prefix push 1011
        set_push(4'b1011, 32'h1);
        #1;
        check("p3_accept", 64'(push_accept_cnt), 64'd2);
        tick();
        push_valid = '0;
        #1;
        check("p3_count", 64'(count), 64'd2);
        check("p3_pop_valid", 64'(pop_valid), 64'b0011);
        check("p3_lane0", 64'(pop_data[0]), 64'h1);
        check("p3_lane1", 64'(pop_data[1]), 64'h2);

        // 4. fill to 6, then push 4 + pop 2 with ready limited by registered count
        set_push(4'b1111, 32'h5);
        tick();
        push_valid = '0;
        #1;
        check("p4_count6", 64'(count), 64'd6);
        set_push(4'b1111, 32'h9);
        pop_cnt = 3'd2;
        #1;
        check("p4_ready", 64'(push_ready_cnt), 64'd2);
        check("p4_accept", 64'(push_accept_cnt), 64'd2);
        tick();
        push_valid = '0;
        pop_cnt = '0;
        #1;
        check("p4_count", 64'(count), 64'd6);
        check("p4_full", 64'(full), 64'd0);
        check("p4_lane0", 64'(pop_data[0]), 64'h5);
        check("p4_lane3", 64'(pop_data[3]), 64'h8);

        set_push(4'b1111, 32'hD);
        tick();
        set_push(4'b0001, 32'hEE);
        #1;
        check("full_flag", 64'(full), 64'd1);
        check("full_ready", 64'(push_ready_cnt), 64'd0);
        check("full_accept", 64'(push_accept_cnt), 64'd0);
        push_valid = '0;
        pop_cnt = 3'd4;
        tick();
        #1;
        check("drain_lane0", 64'(pop_data[0]), 64'h9);
        check("drain_lane2", 64'(pop_data[2]), 64'hD);
        check("drain_lane3", 64'(pop_data[3]), 64'hE);
        tick();
        pop_cnt = '0;
        #1;
        check("drain_empty", 64'(empty), 64'd1);

        // 5. wrap: push 4 / pop 4, six times
        for (int it = 0; it < 6; it++) begin
            set_push(4'b1111, 32'h100 + DW'(4 * it));
            tick();
            push_valid = '0;
            #1;
            check("wrap_count", 64'(count), 64'd4);
            for (int l = 0; l < LANES; l++)
                check("wrap_data", 64'(pop_data[l]), 64'(32'h100 + 32'(4 * it + l)));
            pop_cnt = 3'd4;
            tick();
            pop_cnt = '0;
        end
        set_push(4'b0111, 32'h200);
        tick();
        push_valid = '0;
        pop_cnt = 3'd4;
        tick();
        pop_cnt = '0;
        #1;
        check("clamp_count", 64'(count), 64'd0);
        check("clamp_empty", 64'(empty), 64'd1);
        set_push(4'b0001, 32'h555);
        tick();
        push_valid = '0;
        #1;
        check("clamp_next_count", 64'(count), 64'd1);
        check("clamp_next_data", 64'(pop_data[0]), 64'h555);

        // 6. flush at count 5 with a full push pending
        set_push(4'b1111, 32'h300);
        tick();
        #1;
        check("p6_count5", 64'(count), 64'd5);
        set_push(4'b1111, 32'hDEAD);
        flush = 1'b1;
        #1;
        check("p6_accept", 64'(push_accept_cnt), 64'd0);
        tick();
        flush = 1'b0;
        push_valid = '0;
        #1;
        check("p6_count", 64'(count), 64'd0);
        check("p6_empty", 64'(empty), 64'd1);
        check("p6_pop_valid", 64'(pop_valid), 64'h0);
        set_push(4'b0001, 32'h777);
        tick();
        push_valid = '0;
        #1;
        check("p6_after_count", 64'(count), 64'd1);
        check("p6_after_data", 64'(pop_data[0]), 64'h777);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
